// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1-style TAP controller: 16-state FSM, IR with BYPASS/IDCODE decode and
// SoC-facing data registers (SAMPLE capture, TESTSEL pattern select, SOCRESET).
module jtag_tap_ctrl #(
  parameter int          WIDTH  = 32,
  parameter int          IR_W   = 4,
  parameter int          SEL_W  = 2,
  parameter logic [31:0] IDCODE = 32'h1000_0001
) (
  input  logic             TCK,
  input  logic             TRST,
  input  logic             TMS,
  input  logic             TDI,
  output logic             TDO,
  output logic             TDO_EN,
  input  logic [WIDTH-1:0] socOutput,
  output logic             socRST,
  output logic [SEL_W-1:0] socTestSel
);

  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
  } tap_state_t;

  typedef enum logic [2:0] {
    DR_BYPASS, DR_IDCODE, DR_SAMPLE, DR_TESTSEL, DR_SOCRESET
  } dr_sel_t;

  // BYPASS (all ones) is not listed: it and every undefined opcode fall to the default.
  localparam logic [IR_W-1:0] OP_IDCODE   = IR_W'(1);
  localparam logic [IR_W-1:0] OP_SAMPLE   = IR_W'(2);
  localparam logic [IR_W-1:0] OP_TESTSEL  = IR_W'(3);
  localparam logic [IR_W-1:0] OP_SOCRESET = IR_W'(4);

  tap_state_t       state;
  dr_sel_t          dr_sel;
  logic [IR_W-1:0]  ir;
  logic [IR_W-1:0]  ir_sr;
  logic             bypass_sr;
  logic [31:0]      idcode_sr;
  logic [WIDTH-1:0] sample_sr;
  logic [SEL_W-1:0] testsel_sr;
  logic             socrst_sr;

  function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
    case (s)
      TLR:     return tms ? TLR    : RTI;
      RTI:     return tms ? SEL_DR : RTI;
      SEL_DR:  return tms ? SEL_IR : CAP_DR;
      CAP_DR:  return tms ? EX1_DR : SH_DR;
      SH_DR:   return tms ? EX1_DR : SH_DR;
      EX1_DR:  return tms ? UPD_DR : PAU_DR;
      PAU_DR:  return tms ? EX2_DR : PAU_DR;
      EX2_DR:  return tms ? UPD_DR : SH_DR;
      UPD_DR:  return tms ? SEL_DR : RTI;
      SEL_IR:  return tms ? TLR    : CAP_IR;
      CAP_IR:  return tms ? EX1_IR : SH_IR;
      SH_IR:   return tms ? EX1_IR : SH_IR;
      EX1_IR:  return tms ? UPD_IR : PAU_IR;
      PAU_IR:  return tms ? EX2_IR : PAU_IR;
      EX2_IR:  return tms ? UPD_IR : SH_IR;
      UPD_IR:  return tms ? SEL_DR : RTI;
      default: return TLR;
    endcase
  endfunction

  always_comb begin
    dr_sel = DR_BYPASS;
    case (ir)
      OP_IDCODE:   dr_sel = DR_IDCODE;
      OP_SAMPLE:   dr_sel = DR_SAMPLE;
      OP_TESTSEL:  dr_sel = DR_TESTSEL;
      OP_SOCRESET: dr_sel = DR_SOCRESET;
      default:     dr_sel = DR_BYPASS;
    endcase
  end

  // Test-logic-reset acts like TRST on every edge spent there, so a half-shifted
  // register can never reach an update.
  always_ff @(posedge TCK) begin
    state <= TRST ? TLR : tap_next(state, TMS);
    if (TRST || state == TLR) begin
      ir         <= OP_IDCODE;
      ir_sr      <= '0;
      bypass_sr  <= 1'b0;
      idcode_sr  <= '0;
      sample_sr  <= '0;
      testsel_sr <= '0;
      socrst_sr  <= 1'b0;
      socRST     <= 1'b0;
      socTestSel <= '0;
    end else begin
      case (state)
        CAP_IR: ir_sr <= IR_W'(2'b01);
        SH_IR:  ir_sr <= {TDI, ir_sr[IR_W-1:1]};
        UPD_IR: ir    <= ir_sr;
        CAP_DR: begin
          case (dr_sel)
            DR_IDCODE:   idcode_sr  <= IDCODE;
            DR_SAMPLE:   sample_sr  <= socOutput;
            DR_TESTSEL:  testsel_sr <= socTestSel;
            DR_SOCRESET: socrst_sr  <= socRST;
            default:     bypass_sr  <= 1'b0;
          endcase
        end
        SH_DR: begin
          case (dr_sel)
            DR_IDCODE:   idcode_sr  <= {TDI, idcode_sr[31:1]};
            DR_SAMPLE:   sample_sr  <= {TDI, sample_sr[WIDTH-1:1]};
            DR_TESTSEL:  testsel_sr <= (testsel_sr >> 1) | (SEL_W'(TDI) << (SEL_W - 1));
            DR_SOCRESET: socrst_sr  <= TDI;
            default:     bypass_sr  <= TDI;
          endcase
        end
        UPD_DR: begin
          if (dr_sel == DR_TESTSEL)  socTestSel <= testsel_sr;
          if (dr_sel == DR_SOCRESET) socRST     <= socrst_sr;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    TDO_EN = (state == SH_IR) || (state == SH_DR);
    TDO    = 1'b0;
    if (state == SH_IR) begin
      TDO = ir_sr[0];
    end else if (state == SH_DR) begin
      case (dr_sel)
        DR_IDCODE:   TDO = idcode_sr[0];
        DR_SAMPLE:   TDO = sample_sr[0];
        DR_TESTSEL:  TDO = testsel_sr[0];
        DR_SOCRESET: TDO = socrst_sr;
        default:     TDO = bypass_sr;
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Bench for jtag_tap_ctrl: directed scans with literal expectations, then random TMS/TDI/TRST
// traffic checked every cycle against a register-level behavioural model.
module tb_jtag_tap_ctrl;
  localparam int          WIDTH  = 32;
  localparam int          IR_W   = 4;
  localparam int          SEL_W  = 2;
  localparam logic [31:0] IDCODE = 32'h1000_0001;

  logic             TCK = 1'b0;
  logic             TRST, TMS, TDI, TDO, TDO_EN, socRST;
  logic [WIDTH-1:0] socOutput;
  logic [SEL_W-1:0] socTestSel;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  always #5 TCK = ~TCK;

  jtag_tap_ctrl #(.WIDTH(WIDTH), .IR_W(IR_W), .SEL_W(SEL_W), .IDCODE(IDCODE)) dut (
    .TCK(TCK), .TRST(TRST), .TMS(TMS), .TDI(TDI), .TDO(TDO), .TDO_EN(TDO_EN),
    .socOutput(socOutput), .socRST(socRST), .socTestSel(socTestSel)
  );

  // Model: state numbers 0..15 in the order TLR RTI SDR CDR SHDR E1DR PDR E2DR UDR
  // SIR CIR SHIR E1IR PIR E2IR UIR; transitions from lookup tables.
  int               nx0 [16];
  int               nx1 [16];
  int               m_st;
  logic [IR_W-1:0]  m_ir, m_irsr;
  logic [63:0]      m_drsr;
  logic             m_srst;
  logic [SEL_W-1:0] m_tsel;

  function automatic int kind_of(input logic [IR_W-1:0] op);
    case (op)
      4'd1:    return 1;
      4'd2:    return 2;
      4'd3:    return 3;
      4'd4:    return 4;
      default: return 0;
    endcase
  endfunction

  function automatic int len_of(input int k);
    if (k == 1) return 32;
    if (k == 2) return WIDTH;
    if (k == 3) return SEL_W;
    return 1;
  endfunction

  task automatic model_step();
    int k;
    k = kind_of(m_ir);
    if (TRST || m_st == 0) begin
      m_ir = IR_W'(1); m_irsr = '0; m_drsr = '0; m_srst = 1'b0; m_tsel = '0;
    end else if (m_st == 10) begin
      m_irsr = IR_W'(1);
    end else if (m_st == 11) begin
      m_irsr = (m_irsr >> 1) | (IR_W'(TDI) << (IR_W - 1));
    end else if (m_st == 15) begin
      m_ir = m_irsr;
    end else if (m_st == 3) begin
      if (k == 1)      m_drsr = 64'(IDCODE);
      else if (k == 2) m_drsr = 64'(socOutput);
      else if (k == 3) m_drsr = 64'(m_tsel);
      else if (k == 4) m_drsr = 64'(m_srst);
      else             m_drsr = '0;
    end else if (m_st == 4) begin
      m_drsr = (m_drsr >> 1) | (64'(TDI) << (len_of(k) - 1));
    end else if (m_st == 8) begin
      if (k == 3) m_tsel = m_drsr[SEL_W-1:0];
      if (k == 4) m_srst = m_drsr[0];
    end
    m_st = TRST ? 0 : (TMS ? nx1[m_st] : nx0[m_st]);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge TCK) begin
    if (chk_en) begin
      logic en, td;
      en = (m_st == 4) || (m_st == 11);
      td = !en ? 1'b0 : (m_st == 11 ? m_irsr[0] : m_drsr[0]);
      chk("tdo_en", 64'(TDO_EN), 64'(en));
      chk("tdo", 64'(TDO), 64'(td));
      chk("soc_rst", 64'(socRST), 64'(m_srst));
      chk("soc_test_sel", 64'(socTestSel), 64'(m_tsel));
    end
  end

  task automatic cyc(input logic tms, input logic tdi);
    TMS = tms;
    TDI = tdi;
    @(posedge TCK);
    model_step();
    #2;
  endtask

  // From RTI: full IR scan, ends back in RTI; dout holds the captured bits seen on TDO.
  task automatic load_ir(input logic [IR_W-1:0] v, output logic [63:0] dout);
    dout = '0;
    cyc(1, 0); cyc(1, 0); cyc(0, 0); cyc(0, 0);
    for (int i = 0; i < IR_W; i++) begin
      dout[i] = TDO;
      cyc(i == IR_W - 1, v[i]);
    end
    cyc(1, 0); cyc(0, 0);
  endtask

  // From RTI: DR scan of n bits, optional pause after pause_at bits, ends in RTI.
  task automatic scan_dr(input int n, input logic [63:0] din, input int pause_at,
                         output logic [63:0] dout);
    dout = '0;
    cyc(1, 0); cyc(0, 0); cyc(0, 0);
    for (int i = 0; i < n; i++) begin
      dout[i] = TDO;
      cyc((i == n - 1) || (i == pause_at - 1), din[i]);
      if (i == pause_at - 1 && i != n - 1) begin
        cyc(0, 0); cyc(0, 0); cyc(1, 0); cyc(0, 0);
      end
    end
    cyc(1, 0); cyc(0, 0);
  endtask

  initial begin
    logic [63:0] d;
    nx0 = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
    nx1 = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};
    m_st = 0; m_ir = '0; m_irsr = '0; m_drsr = '0; m_srst = 1'b0; m_tsel = '0;
    TRST = 1'b1; TMS = 1'b1; TDI = 1'b0; socOutput = '0;

    cyc(1, 0);
    TRST = 1'b0;
    chk_en = 1'b1;
    chk("rst_tdo_en", 64'(TDO_EN), 64'd0);
    chk("rst_soc_rst", 64'(socRST), 64'd0);
    chk("rst_test_sel", 64'(socTestSel), 64'd0);
    cyc(0, 0);

    scan_dr(32, 64'h0, 0, d);
    chk("idcode_scan", d[31:0], 64'h1000_0001);

    load_ir(4'hF, d);
    chk("ir_capture", d[1:0], 64'b01);
    scan_dr(4, 64'b1101, 0, d);
    chk("bypass_delay", d[3:0], 64'b1010);

    load_ir(4'd3, d);
    scan_dr(2, 64'b10, 0, d);
    chk("testsel_update", 64'(socTestSel), 64'b10);
    scan_dr(2, 64'b10, 0, d);
    chk("testsel_capture", d[1:0], 64'b10);

    // Enter SH_DR, then five TMS=1 to TLR (passing UPD_DR loads socTestSel=01)
    cyc(1, 0); cyc(0, 0); cyc(0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 0);
    chk("tms_tlr_testsel_pre", 64'(socTestSel), 64'b01);
    cyc(1, 0);
    chk("tlr_testsel_clear", 64'(socTestSel), 64'd0);
    cyc(0, 0);
    scan_dr(32, 64'h0, 0, d);
    chk("tlr_ir_idcode", d[31:0], 64'h1000_0001);

    load_ir(4'd2, d);
    socOutput = 32'hDEAD_BEEF;
    scan_dr(32, 64'(32'h1234_5678), 16, d);
    chk("sample_paused", d[31:0], 64'hDEAD_BEEF);

    load_ir(4'd4, d);
    cyc(1, 0); cyc(0, 0); cyc(0, 0); cyc(1, 1);
    TRST = 1'b1;
    cyc(0, 0);
    TRST = 1'b0;
    chk("trst_mid_scan_socrst", 64'(socRST), 64'd0);
    chk("trst_mid_scan_en", 64'(TDO_EN), 64'd0);
    cyc(0, 0);
    load_ir(4'd4, d);
    scan_dr(1, 64'd1, 0, d);
    chk("socrst_set", 64'(socRST), 64'd1);
    scan_dr(1, 64'd0, 0, d);
    chk("socrst_capture", d[0:0], 64'd1);
    chk("socrst_clear", 64'(socRST), 64'd0);

    for (int i = 0; i < 4000; i++) begin
      TRST = ($urandom_range(0, 99) == 0);
      socOutput = $urandom;
      cyc($urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)));
    end
    TRST = 1'b0;
    cyc(1, 0);
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
